// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds, optional first-word-fall-through
// read mode and one-cycle overflow/underflow pulses.
module sync_fifo #(
  parameter  int DEPTH      = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  parameter  int FWFT       = 0,
  localparam int PTR_WIDTH  = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  // Parameter legality is checked while elaborating.
  if ((DEPTH < 2) || (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_param_err
    $error("sync_fifo: illegal parameters (need DEPTH>=2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH)");
  end

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 af_q, af_d;
  logic                 ae_q, ae_d;
  logic                 ovf_q, udf_q;
  logic                 wr_ok, rd_ok;

  // Requests are accepted against the registered flags only, so there is
  // never a combinational path from w_en/r_en into the flags.
  assign wr_ok = w_en & ~full_q;
  assign rd_ok = r_en & ~empty_q;

  // Next pointers (explicit wrap so non-power-of-two depths work), next
  // count, and flags derived from the next count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_WIDTH'(1);
    end
    if (rd_ok) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_WIDTH'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
  end

  // Control state: pointers, occupancy, flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= w_en & full_q;
      udf_q   <= r_en & empty_q;
    end
  end

  // Storage array; contents survive reset and are simply overwritten later.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; a write into an empty FIFO appears only
    // after the edge that stores it.
    assign data_out = mem_q[rptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered pop: the head word is loaded on each accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem_q[rptr_q];
      end
    end

    assign data_out = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table plus hand sequences for sync_fifo.
// Instance A: DEPTH=5, AF=3, AE=2, standard read. Instance B: DEPTH=8, FWFT.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A (standard mode, depth 5) ----------------
  logic       rst_a, w_a, r_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [2:0] cnt_a;

  sync_fifo #(.DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) u_a (
    .clk(clk), .rst(rst_a), .w_en(w_a), .r_en(r_a), .data_in(din_a),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
  );

  // ---------------- instance B (FWFT mode, depth 8) ----------------
  logic       rst_b, w_b, r_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [3:0] cnt_b;

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_b (
    .clk(clk), .rst(rst_b), .w_en(w_b), .r_en(r_b), .data_in(din_b),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] din,
                              input logic [7:0] dout, input logic [2:0] cnt,
                              input logic full, input logic empty, input logic af,
                              input logic ae, input logic ovf, input logic udf);
    vec_t v;
    v.w = w; v.r = r; v.din = din; v.dout = dout; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] dout, input logic [2:0] cnt,
                       input logic full, input logic empty, input logic af,
                       input logic ae, input logic ovf, input logic udf);
    chk({tag, ".data_out"},     32'(dout_a),  32'(dout));
    chk({tag, ".count"},        32'(cnt_a),   32'(cnt));
    chk({tag, ".full"},         32'(full_a),  32'(full));
    chk({tag, ".empty"},        32'(empty_a), 32'(empty));
    chk({tag, ".almost_full"},  32'(af_a),    32'(af));
    chk({tag, ".almost_empty"}, 32'(ae_a),    32'(ae));
    chk({tag, ".overflow"},     32'(ovf_a),   32'(ovf));
    chk({tag, ".underflow"},    32'(udf_a),   32'(udf));
  endtask

  // One clock on instance A with the given request; sampled 1 time unit
  // after the edge, then requests are dropped again.
  task automatic step_a(input logic w, input logic r, input logic [7:0] din);
    w_a = w; r_a = r; din_a = din;
    @(posedge clk);
    #1;
    w_a = 1'b0; r_a = 1'b0;
  endtask

  task automatic step_b(input logic w, input logic r, input logic [7:0] din);
    w_b = w; r_b = r; din_b = din;
    @(posedge clk);
    #1;
    w_b = 1'b0; r_b = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
  endtask

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] model_q[$];
    logic [7:0] exp_word;
    int         n_wr;

    rst_a = 1'b1; w_a = 1'b0; r_a = 1'b0; din_a = 8'h00;
    rst_b = 1'b1; w_b = 1'b0; r_b = 1'b0; din_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // ---- reset state ----
    chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("reset A: count=%0d empty=%0b data_out=%0h", cnt_a, empty_a, dout_a);

    // ---- vector table: fill, overflow, drain, underflow, simultaneous ops ----
    //              w     r     din     dout   cnt  full  empty af    ae    ovf   udf
    vecs.push_back(mk(1'b1, 1'b0, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h22, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h33, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h44, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h55, 8'h00, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h66, 8'h00, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h22, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h33, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h44, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h55, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h55, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    // simultaneous at empty: read dropped, write kept
    vecs.push_back(mk(1'b1, 1'b1, 8'hBB, 8'h55, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hBB, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    // refill, then simultaneous at full: write dropped, read kept
    vecs.push_back(mk(1'b1, 1'b0, 8'h01, 8'hBB, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h02, 8'hBB, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h03, 8'hBB, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h04, 8'hBB, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h05, 8'hBB, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 8'h01, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h02, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h04, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h05, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    // 0xAA must not have been stored: the FIFO is empty again
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h05, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].w, vecs[i].r, vecs[i].din);
      $display("vec %0d: w=%0b r=%0b din=%0h -> data_out=%0h count=%0d full=%0b empty=%0b af=%0b ae=%0b ovf=%0b udf=%0b",
               i, vecs[i].w, vecs[i].r, vecs[i].din, dout_a, cnt_a, full_a, empty_a,
               af_a, ae_a, ovf_a, udf_a);
      chk_a($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].full,
            vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf);
    end

    // ---- pointer wrap: 12 writes / 12 reads, count oscillating 0..4 ----
    reset_a();
    n_wr = 0;
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 4; k++) begin
        exp_word = 8'hA0 + 8'(n_wr);
        model_q.push_back(exp_word);
        n_wr++;
        step_a(1'b1, 1'b0, exp_word);
        $display("wrap write %0d: din=%0h count=%0d", n_wr - 1, exp_word, cnt_a);
        chk($sformatf("wrap_wr%0d.count", n_wr - 1), 32'(cnt_a), 32'(model_q.size()));
      end
      for (int k = 0; k < 4; k++) begin
        exp_word = model_q.pop_front();
        step_a(1'b0, 1'b1, 8'h00);
        $display("wrap read: data_out=%0h count=%0d", dout_a, cnt_a);
        chk($sformatf("wrap_rd%0d_%0d.data", round, k), 32'(dout_a), 32'(exp_word));
        chk($sformatf("wrap_rd%0d_%0d.count", round, k), 32'(cnt_a), 32'(model_q.size()));
      end
    end
    chk("wrap.empty", 32'(empty_a), 32'd1);

    // ---- back-to-back write+read while partially filled ----
    step_a(1'b1, 1'b0, 8'hC0);
    for (int k = 1; k <= 4; k++) begin
      step_a(1'b1, 1'b1, 8'hC0 + 8'(k));
      $display("b2b %0d: data_out=%0h count=%0d", k, dout_a, cnt_a);
      chk($sformatf("b2b%0d.data", k), 32'(dout_a), 32'(8'hC0 + 8'(k - 1)));
      chk($sformatf("b2b%0d.count", k), 32'(cnt_a), 32'd1);
    end
    step_a(1'b0, 1'b1, 8'h00);
    chk("b2b_last.data", 32'(dout_a), 32'h000000C4);

    // ---- mid-operation reset with count=3 and both requests high ----
    step_a(1'b1, 1'b0, 8'hD1);
    step_a(1'b1, 1'b0, 8'hD2);
    step_a(1'b1, 1'b0, 8'hD3);
    chk("pre_rst.count", 32'(cnt_a), 32'd3);
    w_a = 1'b1; r_a = 1'b1; din_a = 8'h99; rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0; w_a = 1'b0; r_a = 1'b0;
    $display("mid reset: count=%0d empty=%0b ae=%0b data_out=%0h", cnt_a, empty_a, ae_a, dout_a);
    chk_a("midrst", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 8'h77);
    chk("post_rst_wr.count", 32'(cnt_a), 32'd1);
    step_a(1'b0, 1'b1, 8'h00);
    $display("post reset read: data_out=%0h count=%0d", dout_a, cnt_a);
    chk("post_rst_rd.data", 32'(dout_a), 32'h00000077);
    chk("post_rst_rd.empty", 32'(empty_a), 32'd1);

    // ---- FWFT instance ----
    chk("fwft_reset.empty", 32'(empty_b), 32'd1);
    chk("fwft_reset.count", 32'(cnt_b), 32'd0);
    step_b(1'b1, 1'b0, 8'h3C);
    $display("fwft write 3C: data_out=%0h empty=%0b count=%0d", dout_b, empty_b, cnt_b);
    chk("fwft_wr.data", 32'(dout_b), 32'h0000003C);
    chk("fwft_wr.empty", 32'(empty_b), 32'd0);
    chk("fwft_wr.count", 32'(cnt_b), 32'd1);
    step_b(1'b0, 1'b1, 8'h00);
    $display("fwft pop: empty=%0b count=%0d", empty_b, cnt_b);
    chk("fwft_pop.empty", 32'(empty_b), 32'd1);
    chk("fwft_pop.count", 32'(cnt_b), 32'd0);
    step_b(1'b1, 1'b0, 8'h5A);
    step_b(1'b1, 1'b0, 8'h6B);
    $display("fwft two writes: data_out=%0h count=%0d", dout_b, cnt_b);
    chk("fwft_head.data", 32'(dout_b), 32'h0000005A);
    chk("fwft_head.count", 32'(cnt_b), 32'd2);
    step_b(1'b0, 1'b1, 8'h00);
    $display("fwft pop: data_out=%0h count=%0d", dout_b, cnt_b);
    chk("fwft_next.data", 32'(dout_b), 32'h0000006B);
    chk("fwft_next.count", 32'(cnt_b), 32'd1);
    step_b(1'b0, 1'b1, 8'h00);
    chk("fwft_drain.empty", 32'(empty_b), 32'd1);
    step_b(1'b0, 1'b1, 8'h00);
    $display("fwft extra pop: underflow=%0b count=%0d", udf_b, cnt_b);
    chk("fwft_udf.underflow", 32'(udf_b), 32'd1);
    chk("fwft_udf.count", 32'(cnt_b), 32'd0);
    step_b(1'b0, 1'b0, 8'h00);
    chk("fwft_udf_clear.underflow", 32'(udf_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
